// File: rtl/uc_seq.sv
//==============================================================================
// Module   : uc_seq
// Brief    : Sequenced control unit for the single-cycle microcontroller
//            datapath. Adds a boot cycle, a halt state, single-step debug
//            and a retired-instruction counter on top of the opcode decoder.
//            Optional build macro: UC_ILLEGAL_TRAP_EN (illegal opcodes trap
//            to HALT and set the sticky illegal flag; otherwise they act as
//            nop and the illegal port is held low).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uc_seq #(
    parameter int         CNT_W    = 16,
    parameter logic [2:0] ALU_PASS = 3'b000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             zero,
    input  logic             step_mode,
    input  logic             step,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we,
    output logic             wez,
    output logic [2:0]       ALUOp,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_BOOT = 3'd0,
        ST_RUN  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EXEC = 3'd3,
        ST_HALT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               step_q, step_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic w_exec;       // an instruction may execute this cycle
    logic w_cls_li;
    logic w_cls_ill;
    logic w_trap;       // illegal opcode that traps to HALT
    logic w_retire;     // instruction completes and is counted
    logic w_halt_req;   // executing instruction sends the FSM to HALT

    // Opcode[1:0] overlaps RA1/inm, so the ALU/li/nop/illegal classes only
    // look at Opcode[5:2]; jump and halt need all six bits.
    assign w_exec    = (state_q == ST_RUN) || (state_q == ST_EXEC);
    assign w_cls_li  = (Opcode[5:2] == 4'b0100);
    assign w_cls_ill = (Opcode[5:2] == 4'b0101) || (Opcode[5:3] == 3'b011);

`ifdef UC_ILLEGAL_TRAP_EN
    assign w_trap = w_exec && w_cls_ill;
`else
    assign w_trap = 1'b0;
`endif

    // Control decode: inert unless executing; halt/trap freeze everything
    always_comb begin
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        we         = 1'b0;
        wez        = 1'b0;
        ALUOp      = 3'b000;
        pc_en      = 1'b0;
        w_retire   = 1'b0;
        w_halt_req = 1'b0;
        if (w_exec) begin
            if (w_trap || (Opcode == 6'b000011)) begin
                w_halt_req = 1'b1;
            end else if (Opcode[5]) begin
                ALUOp    = Opcode[4:2];
                we       = 1'b1;
                wez      = 1'b1;
                pc_en    = 1'b1;
                w_retire = 1'b1;
            end else if (w_cls_li) begin
                ALUOp    = ALU_PASS;
                s_inm    = 1'b1;
                we       = 1'b1;
                pc_en    = 1'b1;
                w_retire = 1'b1;
            end else if (Opcode == 6'b000000) begin
                s_inc    = 1'b0;
                pc_en    = 1'b1;
                w_retire = 1'b1;
            end else if (Opcode == 6'b000001) begin
                s_inc    = ~zero;
                pc_en    = 1'b1;
                w_retire = 1'b1;
            end else if (Opcode == 6'b000010) begin
                s_inc    = zero;
                pc_en    = 1'b1;
                w_retire = 1'b1;
            end else begin
                // nop, and illegal opcodes when they do not trap
                pc_en    = 1'b1;
                w_retire = 1'b1;
            end
        end
    end

    // Sequencer next state; step_mode falling wins over a step edge in WAIT
    always_comb begin
        state_d   = state_q;
        step_d    = step;
        retired_d = retired_q;
        if (w_retire) begin
            retired_d = retired_q + C_ONE;
        end
        case (state_q)
            ST_BOOT: state_d = step_mode ? ST_WAIT : ST_RUN;
            ST_RUN,
            ST_EXEC: begin
                if (w_halt_req) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = step_mode ? ST_WAIT : ST_RUN;
                end
            end
            ST_WAIT: begin
                if (!step_mode) begin
                    state_d = ST_RUN;
                end else if (step && !step_q) begin
                    state_d = ST_EXEC;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    // State, step history and retired counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_BOOT;
            step_q    <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            retired_q <= retired_d;
        end
    end

`ifdef UC_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;

    // Sticky illegal flag, cleared only by reset
    always_comb begin
        illegal_d = illegal_q | w_trap;
    end

    // Illegal flag register
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign halted  = (state_q == ST_HALT);
    assign retired = retired_q;

endmodule

`default_nettype wire

// File: doc/uc_seq.md
Name: uc_seq

Overview:
- Sequenced control unit for the single-cycle microcontroller datapath.
- Consumes the datapath's Opcode[5:0] and registered zero flag.
- Drives the datapath controls s_inc, s_inm, we, wez and ALUOp, plus a new PC load-enable pc_en.
- Adds a boot cycle, a halt state, a single-step debug mode and a retired-instruction counter, so the datapath can be frozen without corrupting state.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- ALU_PASS, 3'b000, ALUOp code that makes the ALU output operand B; used by li.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- Opcode  input  6  instruction bits [15:10] from the datapath.
- zero  input  1  registered zero flag from the datapath.
- step_mode  input  1  1 = single-step, 0 = free-run.
- step  input  1  step request, level; rising edge is detected internally.
- s_inc  output  1  1 = PC+1, 0 = jump target.
- s_inm  output  1  1 = immediate operand / WA3 read port.
- we  output  1  register-file write enable.
- wez  output  1  zero-flag write enable.
- ALUOp  output  3  ALU operation.
- pc_en  output  1  PC load enable; 0 freezes the PC.
- halted  output  1  high while in HALT.
- illegal  output  1  sticky illegal-opcode flag.
- retired  output  CNT_W  count of executed instructions.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: state=BOOT, step_q=0, retired=0, illegal=0.
- Outputs in BOOT: pc_en=0, we=0, wez=0, s_inc=1, s_inm=0, ALUOp=0, halted=0.
- States: BOOT, RUN, WAIT, EXEC, HALT.
- BOOT: lasts exactly 1 cycle after reset deasserts. Next state is RUN if step_mode=0, else WAIT.
- RUN: executes one instruction per cycle. When step_mode=1, next state is WAIT; the current instruction still executes.
- WAIT: all controls inert (pc_en=0, we=0, wez=0).
  - If step_q=0 and step=1 (rising edge), go to EXEC.
  - If step_mode=0, go to RUN.
- EXEC: executes exactly one instruction, then returns to WAIT, or to RUN if step_mode=0.
- Decode, only in an executing state (RUN or EXEC); otherwise controls are inert:
  - 1ooo xx: ALU reg-reg. ALUOp=Opcode[4:2], s_inm=0, we=1, wez=1, s_inc=1, pc_en=1.
  - 0100 xx: li. ALUOp=ALU_PASS, s_inm=1, we=1, wez=0, s_inc=1, pc_en=1.
  - 000000: j. s_inc=0, pc_en=1, we=0, wez=0.
  - 000001: jz. s_inc = ~zero.
  - 000010: jnz. s_inc = zero.
  - 000011: halt. pc_en=0, we=0, wez=0; next state HALT; retired not incremented.
  - 0001xx: nop. pc_en=1, s_inc=1, we=0, wez=0.
  - 0101xx, 011xxx: illegal; handling set by UC_ILLEGAL_TRAP_EN.
- Decoder scope: only Opcode[5:2] is decoded for ALU/li/nop/illegal classes, because Opcode[1:0] overlaps RA1/inm. Jump and halt classes decode all 6 bits.
- HALT: all controls inert, halted=1. Left only by reset; step and step_mode are ignored.
- retired: increments by 1 (mod 2^CNT_W) at the end of every executing cycle except halt and trapped illegal. Wraps from all-ones to 0.
- step_q: register of step, updated every cycle. A step held high gives exactly one EXEC. A step already high when entering WAIT does not trigger.
- Simultaneous events:
  - reset overrides everything.
  - step edge and step_mode falling in the same WAIT cycle: go to RUN, single execution is not duplicated.
- All outputs are combinational from state, Opcode and zero. Latency from Opcode change to control outputs is 0 cycles.

Optional Feature:
- Macro: UC_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in an executing state sets illegal=1 and moves to HALT, with pc_en=0, we=0, wez=0 that cycle. retired is not incremented.
- Undefined: an illegal opcode behaves as nop (PC+1, counted in retired). The illegal port still exists, held 0.

Test Plan:
- Reset 2 cycles, release, step_mode=0, Opcode=6'b100100 -> cycle 1: pc_en=0, we=0; cycle 2: we=1, wez=1, ALUOp=3'b001, s_inc=1; retired=1 after.
- RUN, Opcode=000001: zero=1 -> s_inc=0, pc_en=1. zero=0 -> s_inc=1. jnz checked with the inverse values.
- RUN, Opcode=000011 -> pc_en=0, we=0 that cycle; halted=1 next. Toggle step/step_mode for 10 cycles -> no change. reset -> BOOT.
- step_mode=1, hold step high 5 cycles, Opcode=6'b010000 -> exactly one cycle with we=1, s_inm=1, ALUOp=ALU_PASS; retired +1 only.
- CNT_W=4, 16 ALU ops in RUN -> retired wraps 4'hF to 4'h0.
- Opcode=6'b011000: with UC_ILLEGAL_TRAP_EN -> illegal=1, halted=1, retired unchanged. Without it -> pc_en=1, s_inc=1, retired +1, illegal=0.
